// File: rtl/proc_pkg.sv
// Shared definitions for the 2-bit-opcode processor: opcode values and the
// fetch FSM state encoding, used by the fetch unit and the control decoder.
package proc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_NOP = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StFetch = 2'b01,
        StSkid  = 2'b10,
        StDrop  = 2'b11
    } fetch_state_e;

    function automatic logic is_jump(input logic [1:0] op);
        return op == OP_JMP;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction+PC holding buffer used when a fetch response arrives
// while the IF/ID register is stalled.
module fetch_skid_buf #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               unload_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end
        // Clear wins over a coincident load: a redirect invalidates everything.
        if (unload_i || clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, fetches over a req/ack handshake, holds the
// IF/ID register and handles decode-driven redirects.
module instr_fetch_unit
    import proc_pkg::*;
#(
    parameter int unsigned    PC_W     = 8,
    parameter int unsigned    INSTR_W  = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               PC_Source,
    input  logic [PC_W-1:0]    Jump_Target,
    output logic               Instr_Valid,
    output logic [INSTR_W-1:0] Instr,
    output logic [PC_W-1:0]    Instr_PC,
    output logic [1:0]         Op_Code
);

    localparam logic [PC_W-1:0] PcOne = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    drop_addr_q, drop_addr_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    instr_pc_q, instr_pc_d;

    logic               skid_load, skid_unload, skid_clear;
    logic               skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;

    logic consume, redirect, ack_v;

    assign imem_req  = (state_q == StFetch) || (state_q == StDrop);
    // DROP keeps presenting the abandoned address until its ack arrives.
    assign imem_addr = (state_q == StDrop) ? drop_addr_q : pc_q;

    assign consume  = valid_q && !stall;
    assign redirect = consume && PC_Source;
    assign ack_v    = imem_ack && imem_req;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        if (consume) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (redirect) begin
                    pc_d       = Jump_Target;
                    skid_clear = 1'b1;
                    if (!ack_v) begin
                        state_d     = StDrop;
                        drop_addr_d = pc_q;
                    end
                end else if (ack_v) begin
                    pc_d = pc_q + PcOne;
                    if (!valid_q || consume) begin
                        valid_d    = 1'b1;
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = StSkid;
                    end
                end
            end
            StSkid: begin
                if (!stall) begin
                    skid_unload = 1'b1;
                    state_d     = StFetch;
                    if (redirect) begin
                        pc_d       = Jump_Target;
                        skid_clear = 1'b1;
                    end else if (skid_valid) begin
                        valid_d    = 1'b1;
                        instr_d    = skid_instr;
                        instr_pc_d = skid_pc;
                    end
                end
            end
            StDrop: begin
                if (ack_v) begin
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
            valid_q     <= 1'b0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
        end
    end

    fetch_skid_buf #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .instr_i  (imem_rdata),
        .pc_i     (pc_q),
        .valid_o  (skid_valid),
        .instr_o  (skid_instr),
        .pc_o     (skid_pc)
    );

    assign Instr_Valid = valid_q;
    assign Instr       = instr_q;
    assign Instr_PC    = instr_pc_q;
    assign Op_Code     = valid_q ? instr_q[INSTR_W-1 -: 2] : OP_NOP;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic       stall;
    logic       PC_Source;
    logic [7:0] Jump_Target;
    logic       Instr_Valid;
    logic [7:0] Instr;
    logic [7:0] Instr_PC;
    logic [1:0] Op_Code;

    int errors = 0;
    int checks = 0;

    instr_fetch_unit #(
        .PC_W     (8),
        .INSTR_W  (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .PC_Source   (PC_Source),
        .Jump_Target (Jump_Target),
        .Instr_Valid (Instr_Valid),
        .Instr       (Instr),
        .Instr_PC    (Instr_PC),
        .Op_Code     (Op_Code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic [7:0] rdata, input logic stl);
        imem_ack   = ack;
        imem_rdata = rdata;
        stall      = stl;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, ".req"},   imem_req,    0);
        check_eq({tag, ".addr"},  imem_addr,   8'h00);
        check_eq({tag, ".valid"}, Instr_Valid, 0);
        check_eq({tag, ".instr"}, Instr,       8'h00);
        check_eq({tag, ".ipc"},   Instr_PC,    8'h00);
        check_eq({tag, ".op"},    Op_Code,     2'b10);
    endtask

    task automatic check_ifid(input string tag, input logic [7:0] ins, input logic [7:0] pc);
        check_eq({tag, ".valid"}, Instr_Valid, 1);
        check_eq({tag, ".instr"}, Instr,       ins);
        check_eq({tag, ".ipc"},   Instr_PC,    pc);
        check_eq({tag, ".op"},    Op_Code,     {30'd0, ins[7:6]});
    endtask

    task automatic check_bubble(input string tag);
        check_eq({tag, ".valid"}, Instr_Valid, 0);
        check_eq({tag, ".op"},    Op_Code,     2'b10);
    endtask

    task automatic check_fetch(input string tag, input logic req, input logic [7:0] addr);
        check_eq({tag, ".req"}, imem_req, req);
        if (req) check_eq({tag, ".addr"}, imem_addr, addr);
    endtask

    initial begin
        rst_n       = 1'b0;
        PC_Source   = 1'b0;
        Jump_Target = 8'h00;
        drive(0, 8'h00, 0);
        #1;
        check_reset("rst0");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back fetch, ack every cycle.
        check_fetch("c1", 0, 8'h00);
        check_bubble("c1");
        cyc();
        check_fetch("c2", 1, 8'h00);
        check_bubble("c2");
        drive(1, 8'h05, 0);
        cyc();
        check_ifid("c3", 8'h05, 8'h00);
        check_fetch("c3", 1, 8'h01);
        drive(1, 8'h46, 0);
        cyc();
        check_ifid("c4", 8'h46, 8'h01);
        check_fetch("c4", 1, 8'h02);
        drive(1, 8'h83, 0);
        cyc();
        check_ifid("c5", 8'h83, 8'h02);
        check_fetch("c5", 1, 8'h03);
        drive(1, 8'h07, 0);
        cyc();
        check_ifid("c6", 8'h07, 8'h03);
        check_fetch("c6", 1, 8'h04);

        // Stall for three cycles while ack arrives: response goes to skid.
        drive(1, 8'h11, 1);
        cyc();
        check_ifid("stA", 8'h07, 8'h03);
        check_fetch("stA", 0, 8'h00);
        drive(1, 8'hEE, 1);  // stray ack with no request must be ignored
        cyc();
        check_ifid("stB", 8'h07, 8'h03);
        check_fetch("stB", 0, 8'h00);
        drive(0, 8'h00, 1);
        cyc();
        check_ifid("stC", 8'h07, 8'h03);
        check_fetch("stC", 0, 8'h00);
        drive(0, 8'h00, 0);
        cyc();
        check_ifid("stE", 8'h11, 8'h04);
        check_fetch("stE", 1, 8'h05);
        drive(1, 8'hC0, 0);
        cyc();
        check_ifid("stF", 8'hC0, 8'h05);
        check_fetch("stF", 1, 8'h06);

        // Consumed jump with request outstanding and no ack: DROP.
        drive(0, 8'h00, 0);
        PC_Source   = 1'b1;
        Jump_Target = 8'h40;
        cyc();
        PC_Source = 1'b0;
        check_bubble("drG");
        check_fetch("drG", 1, 8'h06);
        cyc();
        check_bubble("drH");
        check_fetch("drH", 1, 8'h06);
        drive(1, 8'h99, 0);
        cyc();
        check_bubble("drI");
        check_fetch("drI", 1, 8'h40);
        drive(1, 8'h01, 0);
        cyc();
        check_ifid("drJ", 8'h01, 8'h40);
        check_fetch("drJ", 1, 8'h41);

        // Redirect coincident with ack: response discarded.
        drive(1, 8'hAA, 0);
        PC_Source   = 1'b1;
        Jump_Target = 8'hFE;
        cyc();
        PC_Source = 1'b0;
        check_bubble("rdK");
        check_fetch("rdK", 1, 8'hFE);
        drive(1, 8'h3C, 0);
        cyc();
        check_ifid("rdL", 8'h3C, 8'hFE);
        check_fetch("rdL", 1, 8'hFF);

        // PC wrap all-ones -> zero.
        drive(1, 8'h5A, 0);
        cyc();
        check_ifid("wrap", 8'h5A, 8'hFF);
        check_fetch("wrap", 1, 8'h00);

        // Reset mid-request.
        drive(0, 8'h00, 0);
        rst_n = 1'b0;
        #1;
        check_reset("rstReq");
        cyc();
        rst_n = 1'b1;
        check_fetch("r1c1", 0, 8'h00);
        cyc();
        check_fetch("r1c2", 1, 8'h00);
        drive(1, 8'h12, 0);
        cyc();
        check_ifid("r1c3", 8'h12, 8'h00);
        drive(1, 8'h34, 1);
        cyc();
        check_fetch("r1skid", 0, 8'h00);
        check_ifid("r1skid", 8'h12, 8'h00);

        // Reset mid-SKID: skid contents must not reappear.
        drive(0, 8'h00, 0);
        rst_n = 1'b0;
        #1;
        check_reset("rstSkid");
        cyc();
        rst_n = 1'b1;
        check_bubble("r2c1");
        cyc();
        check_fetch("r2c2", 1, 8'h00);
        check_bubble("r2c2");
        drive(1, 8'h56, 0);
        cyc();
        check_ifid("r2c3", 8'h56, 8'h00);
        check_fetch("r2c3", 1, 8'h01);
        drive(0, 8'h00, 0);
        cyc();
        check_bubble("r2c4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
